// File: rtl/id_stage_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// id_stage_pipe : pipelined decode stage - register file, operand/immediate/target
//                 generation, valid/ready handshake and scoreboard hazard stall.
// Optional macro ID_BYPASS_EN enables same-cycle WB->ID forwarding.
// Revision: 1.0
//------------------------------------------------------------------------------
module id_stage_pipe #(
   parameter int DW      = 16,
   parameter int NREG    = 8,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   instruction,
   input  logic [DW-1:0] next_pc,
   input  logic [1:0]    ra_src,
   input  logic          rb_src,
   input  logic          reg_dst,
   input  logic          ext_op,
   input  logic          reg_wr,
   input  logic          use_a,
   input  logic          use_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [3:0]    opcode,
   output logic          mode,
   output logic [2:0]    rw,
   output logic          wr_out,
   output logic [DW-1:0] bus_a,
   output logic [DW-1:0] bus_b,
   output logic [DW-1:0] imm_ext,
   output logic [DW-1:0] b_target,
   output logic [DW-1:0] jump_target,
   input  logic          wb_en,
   input  logic [2:0]    wb_addr,
   input  logic [DW-1:0] wb_data
);
   localparam int AW = $clog2(NREG);

   typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;
   state_t state, state_nx;

   logic [DW-1:0]   regs [NREG];
   logic [NREG-1:0] pend, pend_nx;
   logic [AW-1:0]   ra, rb, rw_idx, wb_idx;
   logic [DW-1:0]   rd_a, rd_b, imm_w;
   logic            busy_a, busy_b, hazard, accept, wb_we;

   assign wb_idx = wb_addr[AW-1:0];
   assign wb_we  = wb_en & ~(R0_ZERO && wb_idx == '0);

   always_comb begin
      case (ra_src)
         2'd0:    ra = instruction[6 +: AW];
         2'd1:    ra = '1;
         default: ra = '0;
      endcase
      rb     = rb_src  ? instruction[9 +: AW] : instruction[3 +: AW];
      rw_idx = reg_dst ? '1 : instruction[9 +: AW];
   end

   // Operand read; with forwarding, a matching write-back supplies data and clears the hazard.
   always_comb begin
      rd_a   = regs[ra];
      rd_b   = regs[rb];
      busy_a = pend[ra];
      busy_b = pend[rb];
`ifdef ID_BYPASS_EN
      if (wb_en && wb_idx == ra) begin
         rd_a   = wb_data;
         busy_a = 1'b0;
      end
      if (wb_en && wb_idx == rb) begin
         rd_b   = wb_data;
         busy_b = 1'b0;
      end
`endif
      if (R0_ZERO && ra == '0) begin
         rd_a   = '0;
         busy_a = 1'b0;
      end
      if (R0_ZERO && rb == '0) begin
         rd_b   = '0;
         busy_b = 1'b0;
      end
   end

   assign hazard   = (use_a & busy_a) | (use_b & busy_b);
   assign in_ready = ~rst & (~out_valid | out_ready) & ~hazard;
   assign accept   = in_valid & in_ready;
   assign out_valid = (state == FULL);

   assign imm_w = ext_op ? {{(DW-5){instruction[4]}}, instruction[4:0]}
                         : {{(DW-5){1'b0}}, instruction[4:0]};

   // A set on accept overrides a same-cycle write-back clear.
   always_comb begin
      pend_nx = pend;
      if (wb_en)
         pend_nx[wb_idx] = 1'b0;
      if (accept && reg_wr && !(R0_ZERO && rw_idx == '0))
         pend_nx[rw_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pend <= '0;
      else
         pend <= pend_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wb_we) begin
         regs[wb_idx] <= wb_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= EMPTY;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:   if (accept) state_nx = FULL;
         FULL:    if (!accept && out_ready) state_nx = EMPTY;
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode      <= '0;
         mode        <= 1'b0;
         rw          <= '0;
         wr_out      <= 1'b0;
         bus_a       <= '0;
         bus_b       <= '0;
         imm_ext     <= '0;
         b_target    <= '0;
         jump_target <= '0;
      end else if (accept) begin
         opcode      <= instruction[15:12];
         mode        <= instruction[11];
         rw          <= 3'(rw_idx);
         wr_out      <= reg_wr;
         bus_a       <= rd_a;
         bus_b       <= rd_b;
         imm_ext     <= imm_w;
         b_target    <= next_pc + imm_w;
         jump_target <= {next_pc[DW-1:10], instruction[8:0], 1'b0};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_id_stage_pipe : directed and randomized checks of id_stage_pipe against a
//                    cycle-level behavioural model. Revision: 1.0
//------------------------------------------------------------------------------
module tb_id_stage_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] instruction, next_pc;
   logic [1:0]  ra_src;
   logic        rb_src, reg_dst, ext_op, reg_wr, use_a, use_b;
   logic        out_valid, out_ready;
   logic [3:0]  opcode;
   logic        mode, wr_out;
   logic [2:0]  rw;
   logic [15:0] bus_a, bus_b, imm_ext, b_target, jump_target;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .next_pc(next_pc), .ra_src(ra_src),
      .rb_src(rb_src), .reg_dst(reg_dst), .ext_op(ext_op), .reg_wr(reg_wr),
      .use_a(use_a), .use_b(use_b), .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .mode(mode), .rw(rw), .wr_out(wr_out),
      .bus_a(bus_a), .bus_b(bus_b), .imm_ext(imm_ext), .b_target(b_target),
      .jump_target(jump_target), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   logic [15:0] m_reg [8];
   bit          m_pend [8];
   bit          m_valid;
   logic [3:0]  m_opcode;
   bit          m_mode, m_wr;
   logic [2:0]  m_rw;
   logic [15:0] m_a, m_b, m_imm, m_bt, m_jt;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_reg[i]  = 16'h0;
         m_pend[i] = 1'b0;
      end
      m_valid = 0; m_opcode = 0; m_mode = 0; m_wr = 0; m_rw = 0;
      m_a = 0; m_b = 0; m_imm = 0; m_bt = 0; m_jt = 0;
   endtask

   function automatic int ra_of();
      if (ra_src == 2'd0) return int'(instruction[8:6]);
      if (ra_src == 2'd1) return 7;
      return 0;
   endfunction

   function automatic int rb_of();
      return rb_src ? int'(instruction[11:9]) : int'(instruction[5:3]);
   endfunction

   function automatic bit src_busy(input int idx);
      if (idx == 0) return 1'b0;
`ifdef ID_BYPASS_EN
      if (wb_en && int'(wb_addr) == idx) return 1'b0;
`endif
      return m_pend[idx];
   endfunction

   function automatic logic [15:0] src_val(input int idx);
      if (idx == 0) return 16'h0;
`ifdef ID_BYPASS_EN
      if (wb_en && int'(wb_addr) == idx) return wb_data;
`endif
      return m_reg[idx];
   endfunction

   function automatic bit exp_ready();
      bit stall;
      stall = (use_a && src_busy(ra_of())) || (use_b && src_busy(rb_of()));
      return !rst && (!m_valid || out_ready) && !stall;
   endfunction

   task automatic idle();
      in_valid = 0; instruction = 16'h0; next_pc = 16'h0; ra_src = 2'd0;
      rb_src = 0; reg_dst = 0; ext_op = 0; reg_wr = 0; use_a = 0; use_b = 0;
      out_ready = 1; wb_en = 0; wb_addr = 3'd0; wb_data = 16'h0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_in_ready"},  in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_opcode"},    opcode, 0);
      check({tag, "_rw"},        rw, 0);
      check({tag, "_bus_a"},     bus_a, 0);
      check({tag, "_bus_b"},     bus_b, 0);
      check({tag, "_imm"},       imm_ext, 0);
      check({tag, "_jt"},        jump_target, 0);
   endtask

   // One clock: compare against the model, then advance the model across the edge.
   task automatic cycle();
      bit          acc;
      logic [15:0] na, nb, nimm;
      int          nrw;
      #1;
      check("in_ready",    in_ready, exp_ready());
      check("out_valid",   out_valid, m_valid);
      check("opcode",      opcode, m_opcode);
      check("mode",        mode, m_mode);
      check("rw",          rw, m_rw);
      check("wr_out",      wr_out, m_wr);
      check("bus_a",       bus_a, m_a);
      check("bus_b",       bus_b, m_b);
      check("imm_ext",     imm_ext, m_imm);
      check("b_target",    b_target, m_bt);
      check("jump_target", jump_target, m_jt);
      acc  = in_valid && exp_ready();
      na   = src_val(ra_of());
      nb   = src_val(rb_of());
      nimm = ext_op ? {{11{instruction[4]}}, instruction[4:0]} : {11'b0, instruction[4:0]};
      nrw  = reg_dst ? 7 : int'(instruction[11:9]);
      @(posedge clk);
      if (acc) begin
         m_valid  = 1;
         m_opcode = instruction[15:12];
         m_mode   = instruction[11];
         m_rw     = 3'(nrw);
         m_wr     = reg_wr;
         m_a      = na;
         m_b      = nb;
         m_imm    = nimm;
         m_bt     = next_pc + nimm;
         m_jt     = {next_pc[15:10], instruction[8:0], 1'b0};
      end else if (out_ready) begin
         m_valid = 0;
      end
      if (wb_en) m_pend[wb_addr] = 0;
      if (acc && reg_wr && nrw != 0) m_pend[nrw] = 1;
      if (wb_en && wb_addr != 3'd0) m_reg[wb_addr] = wb_data;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      @(negedge clk);
      check_zero("por");
      rst = 1'b0;
      cycle();

      // Write-back then read through port A
      wb_en = 1; wb_addr = 3'd3; wb_data = 16'h1234;
      cycle();
      idle();
      in_valid = 1; instruction = {4'h3, 3'd1, 3'd3, 6'd0}; ra_src = 2'd0; use_a = 1;
      cycle();
      idle();
      #1 check("wb_read_valid", out_valid, 1);
      check("wb_read_bus_a", bus_a, 16'h1234);
      cycle();

      // Sign / zero extension and branch target
      in_valid = 1; instruction = 16'h0016; next_pc = 16'h0100; ext_op = 1;
      cycle();
      idle();
      #1 check("sext_imm", imm_ext, 16'hFFF6);
      check("sext_bt", b_target, 16'h00F6);
      in_valid = 1; instruction = 16'h0016; next_pc = 16'h0100; ext_op = 0;
      cycle();
      idle();
      #1 check("zext_imm", imm_ext, 16'h0016);
      check("zext_bt", b_target, 16'h0116);

      // Jump target
      in_valid = 1; instruction = 16'hC1FF; next_pc = 16'h8400;
      cycle();
      idle();
      #1 check("jump_target_fixed", jump_target, 16'h87FE);
      cycle();

      // RAW hazard on R2
      in_valid = 1; instruction = {4'h1, 3'd2, 9'd0}; reg_wr = 1;
      cycle();
      idle();
      in_valid = 1; instruction = {4'h2, 3'd4, 3'd2, 6'd0}; use_a = 1;
      #1 check("haz_stall0", in_ready, 0);
      cycle();
      cycle();
      wb_en = 1; wb_addr = 3'd2; wb_data = 16'h00AA;
`ifdef ID_BYPASS_EN
      #1 check("haz_wb_cycle_ready", in_ready, 1);
      cycle();
      wb_en = 0; in_valid = 0; use_a = 0;
`else
      #1 check("haz_wb_cycle_ready", in_ready, 0);
      cycle();
      wb_en = 0;
      #1 check("haz_after_wb_ready", in_ready, 1);
      cycle();
      in_valid = 0; use_a = 0;
`endif
      #1 check("haz_bus_a", bus_a, 16'h00AA);
      check("haz_valid", out_valid, 1);
      cycle();

      // R0 hard-wired zero
      wb_en = 1; wb_addr = 3'd0; wb_data = 16'hFFFF;
      cycle();
      idle();
      in_valid = 1; instruction = 16'h5000; ra_src = 2'd2; use_a = 1;
      cycle();
      #1 check("r0_bus_a", bus_a, 16'h0000);

      // Downstream back-pressure: outputs hold, no acceptance
      out_ready = 0; instruction = 16'h6ABC; next_pc = 16'h1111; ra_src = 2'd1;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_in_ready", in_ready, 0);
         cycle();
      end

      // Asynchronous reset mid-stall
      #2 rst = 1'b1;
      #1 check_zero("rst_mid");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      idle();
      #1 check("post_rst_ready", in_ready, 1);
      cycle();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         in_valid    = ($urandom_range(0, 9) < 7);
         instruction = 16'($urandom);
         next_pc     = 16'($urandom);
         ra_src      = 2'($urandom_range(0, 3));
         rb_src      = 1'($urandom_range(0, 1));
         reg_dst     = ($urandom_range(0, 9) < 2);
         ext_op      = 1'($urandom_range(0, 1));
         reg_wr      = 1'($urandom_range(0, 1));
         use_a       = 1'($urandom_range(0, 1));
         use_b       = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 9) < 7);
         wb_en       = ($urandom_range(0, 9) < 5);
         wb_addr     = 3'($urandom_range(0, 7));
         wb_data     = 16'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
